dm_sba_engine: RTL and testbench

DM_SBA_ENGINE -- requirements
Module: dm_sba_engine

---
 rtl/dm_pkg.sv | 31 +++
 rtl/dm_sba_lane.sv | 33 +++
 rtl/dm_sba_engine.sv | 191 +++++++++++++++++++
 tb/tb_dm_sba_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared debug-module types: system-bus error codes, access sizes and SBA FSM states.
package dm_pkg;

    typedef enum logic [2:0] {
        SBERR_NONE       = 3'd0,
        SBERR_TIMEOUT    = 3'd1,
        SBERR_BADADDR    = 3'd2,
        SBERR_MISALIGNED = 3'd3,
        SBERR_SIZE       = 3'd4,
        SBERR_OTHER      = 3'd7
    } sberror_e;

    typedef enum logic [2:0] {
        SBA_8   = 3'd0,
        SBA_16  = 3'd1,
        SBA_32  = 3'd2,
        SBA_64  = 3'd3,
        SBA_128 = 3'd4
    } sbaccess_e;

    typedef enum logic [1:0] {
        SBA_IDLE,
        SBA_REQ,
        SBA_WAIT_RESP
    } sba_state_e;

    function automatic int unsigned access_bytes(input logic [2:0] acc);
        return 32'd1 << acc;
    endfunction

endpackage

// File: rtl/dm_sba_lane.sv
// Byte-lane steering for the system-bus master: byte enables, write-data
// placement and read-data extraction for a naturally aligned access.
module dm_sba_lane import dm_pkg::*; #(
    parameter int BusWidth = 32
) (
    input  logic [2:0]                        access_i,
    input  logic [$clog2(BusWidth/8)-1:0]     offset_i,
    input  logic [BusWidth-1:0]               wdata_i,
    input  logic [BusWidth-1:0]               rdata_i,
    output logic [BusWidth/8-1:0]             be_o,
    output logic [BusWidth-1:0]               wdata_o,
    output logic [BusWidth-1:0]               rdata_o
);

    localparam int unsigned NumBytes = BusWidth / 8;

    logic [NumBytes-1:0] size_mask;
    logic [BusWidth-1:0] data_mask;

    always_comb begin
        size_mask = '0;
        data_mask = '0;
        for (int unsigned i = 0; i < NumBytes; i++) begin
            size_mask[i]        = (i < access_bytes(access_i));
            data_mask[i*8 +: 8] = {8{size_mask[i]}};
        end
    end

    assign be_o    = size_mask << offset_i;
    assign wdata_o = wdata_i << {offset_i, 3'b000};
    assign rdata_o = (rdata_i >> {offset_i, 3'b000}) & data_mask;

endmodule

// File: rtl/dm_sba_engine.sv
// System-bus access engine: turns sbaddress/sbdata CSR accesses into single
// master-bus transfers, with access checks, per-phase timeout and autoincrement.
module dm_sba_engine import dm_pkg::*; #(
    parameter int BusWidth       = 32,
    parameter int TimeoutCycles  = 1024,
    parameter bit ReadByteEnable = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic                  master_r_other_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i
);

    localparam int OffW = $clog2(BusWidth / 8);
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    sba_state_e          state_q, state_d;
    logic [BusWidth-1:0] addr_q, add_q, wdata_q, sbdata_q, start_addr, amask;
    logic [2:0]          access_q;
    logic                we_q, data_valid_q, err_valid_q;
    sberror_e            err_q, err_code;
    logic [CntW-1:0]     cnt_q;
    logic                start, start_we, load_addr, launch, err_set, ok_done, rd_done, cnt_clr;
    logic                timeout_hit;

    logic [BusWidth/8-1:0] lane_be;
    logic [BusWidth-1:0]   lane_wdata, lane_rdata;

    dm_sba_lane #(.BusWidth(BusWidth)) u_lane (
        .access_i (access_q),
        .offset_i (add_q[OffW-1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (master_r_rdata_i),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        start_we   = 1'b0;
        load_addr  = 1'b0;
        launch     = 1'b0;
        start_addr = addr_q;
        amask      = '0;
        err_set    = 1'b0;
        err_code   = SBERR_NONE;
        ok_done    = 1'b0;
        rd_done    = 1'b0;
        cnt_clr    = 1'b0;
        case (state_q)
            SBA_IDLE: begin
                // An address write shadows any data trigger in the same cycle.
                if (sbaddress_write_valid_i) begin
                    load_addr  = 1'b1;
                    start_addr = sbaddress_i;
                    start      = sbreadonaddr_i;
                end else if (sbdata_write_valid_i) begin
                    start    = 1'b1;
                    start_we = 1'b1;
                end else if (sbdata_read_valid_i && sbreadondata_i) begin
                    start = 1'b1;
                end
                if (start) begin
                    amask = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);
                    if (sbaccess_i > 3'(OffW)) begin
                        err_set  = 1'b1;
                        err_code = SBERR_SIZE;
                    end else if (|(start_addr & amask)) begin
                        err_set  = 1'b1;
                        err_code = SBERR_MISALIGNED;
                    end else begin
                        launch  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = SBA_REQ;
                    end
                end
            end
            SBA_REQ: begin
                if (master_gnt_i) begin
                    cnt_clr = 1'b1;
                    state_d = SBA_WAIT_RESP;
                end else if (timeout_hit) begin
                    err_set  = 1'b1;
                    err_code = SBERR_TIMEOUT;
                    state_d  = SBA_IDLE;
                end
            end
            SBA_WAIT_RESP: begin
                if (master_r_valid_i) begin
                    state_d = SBA_IDLE;
                    if (master_r_other_err_i) begin
                        err_set  = 1'b1;
                        err_code = SBERR_OTHER;
                    end else if (master_r_err_i) begin
                        err_set  = 1'b1;
                        err_code = SBERR_BADADDR;
                    end else begin
                        ok_done = 1'b1;
                        rd_done = !we_q;
                    end
                end else if (timeout_hit) begin
                    err_set  = 1'b1;
                    err_code = SBERR_TIMEOUT;
                    state_d  = SBA_IDLE;
                end
            end
            default: state_d = SBA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= SBA_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            add_q        <= '0;
            wdata_q      <= '0;
            access_q     <= '0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            sbdata_q     <= '0;
            data_valid_q <= 1'b0;
            err_valid_q  <= 1'b0;
            err_q        <= SBERR_NONE;
        end else begin
            err_valid_q  <= err_set;
            data_valid_q <= rd_done;
            if (err_set) err_q    <= err_code;
            if (rd_done) sbdata_q <= lane_rdata;
            if (load_addr)
                addr_q <= sbaddress_i;
            else if (ok_done && sbautoincrement_i)
                addr_q <= addr_q + BusWidth'(access_bytes(access_q));
            // Transfer attributes are frozen at launch so the bus sees stable values.
            if (launch) begin
                add_q    <= start_addr;
                we_q     <= start_we;
                access_q <= sbaccess_i;
                wdata_q  <= sbdata_i;
            end
            if (cnt_clr || state_q == SBA_IDLE) cnt_q <= '0;
            else                                cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign sbaddress_o     = addr_q;
    assign sbdata_o        = sbdata_q;
    assign sbdata_valid_o  = data_valid_q;
    assign sberror_valid_o = err_valid_q;
    assign sberror_o       = err_q;
    assign sbbusy_o        = (state_q != SBA_IDLE);

    assign master_req_o   = (state_q == SBA_REQ);
    assign master_add_o   = master_req_o ? add_q : '0;
    assign master_we_o    = master_req_o & we_q;
    assign master_wdata_o = master_we_o ? lane_wdata : '0;
    assign master_be_o    = !master_req_o ? '0 :
                            (we_q || ReadByteEnable) ? lane_be : '1;

endmodule

// File: tb/tb_dm_sba_engine.sv
// Bench for dm_sba_engine: table of single transfers on a 32-bit instance with
// a scoreboard of expected CSR-side results, plus 64-bit and reset sequences.
module tb_dm_sba_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] sbaddress, sbdata, rdata;
    logic        aw, roa, ainc, dr, rod, dw, gnt, rvalid, rerr, roth;
    logic [2:0]  acc;
    logic [31:0] n_sbaddress, n_sbdata, n_add, n_wdata;
    logic        n_dvalid, n_busy, n_evalid, n_req, n_we;
    logic [2:0]  n_err;
    logic [3:0]  n_be;

    logic [63:0] w_sbaddress, w_sbdata, w_rdata;
    logic        w_aw, w_roa, w_ainc, w_dr, w_rod, w_dw, w_gnt, w_rvalid, w_rerr, w_roth;
    logic [2:0]  w_acc;
    logic [63:0] w_o_sbaddress, w_o_sbdata, w_add, w_wdata;
    logic        w_dvalid, w_busy, w_evalid, w_req, w_we;
    logic [2:0]  w_err;
    logic [7:0]  w_be;

    dm_sba_engine #(.BusWidth(32), .TimeoutCycles(8), .ReadByteEnable(1'b1)) u_dut32 (
        .clk_i(clk), .rst_i(rst),
        .sbaddress_i(sbaddress), .sbaddress_write_valid_i(aw), .sbreadonaddr_i(roa),
        .sbautoincrement_i(ainc), .sbaccess_i(acc), .sbreadondata_i(rod), .sbdata_i(sbdata),
        .sbdata_read_valid_i(dr), .sbdata_write_valid_i(dw),
        .sbaddress_o(n_sbaddress), .sbdata_o(n_sbdata), .sbdata_valid_o(n_dvalid),
        .sbbusy_o(n_busy), .sberror_valid_o(n_evalid), .sberror_o(n_err),
        .master_req_o(n_req), .master_add_o(n_add), .master_we_o(n_we),
        .master_wdata_o(n_wdata), .master_be_o(n_be), .master_gnt_i(gnt),
        .master_r_valid_i(rvalid), .master_r_err_i(rerr), .master_r_other_err_i(roth),
        .master_r_rdata_i(rdata)
    );

    dm_sba_engine #(.BusWidth(64)) u_dut64 (
        .clk_i(clk), .rst_i(rst),
        .sbaddress_i(w_sbaddress), .sbaddress_write_valid_i(w_aw), .sbreadonaddr_i(w_roa),
        .sbautoincrement_i(w_ainc), .sbaccess_i(w_acc), .sbreadondata_i(w_rod), .sbdata_i(w_sbdata),
        .sbdata_read_valid_i(w_dr), .sbdata_write_valid_i(w_dw),
        .sbaddress_o(w_o_sbaddress), .sbdata_o(w_o_sbdata), .sbdata_valid_o(w_dvalid),
        .sbbusy_o(w_busy), .sberror_valid_o(w_evalid), .sberror_o(w_err),
        .master_req_o(w_req), .master_add_o(w_add), .master_we_o(w_we),
        .master_wdata_o(w_wdata), .master_be_o(w_be), .master_gnt_i(w_gnt),
        .master_r_valid_i(w_rvalid), .master_r_err_i(w_rerr), .master_r_other_err_i(w_roth),
        .master_r_rdata_i(w_rdata)
    );

    typedef struct {
        logic aw, dw, dr, roa, rod, ainc;
        logic [2:0] acc;
        logic [31:0] addr, wdat;
        int gdly;
        logic [31:0] rdat;
        logic rerr, roth;
        int req_cyc;
        logic [31:0] madd;
        logic [3:0] be;
        logic [31:0] wd;
        logic xev_err;
        logic [2:0] xerr;
        logic xev_dat;
        logic [31:0] xdat, xaddr;
    } vec_t;

    typedef struct {
        logic ev_err;
        logic [2:0] err;
        logic ev_dat;
        logic [31:0] dat;
    } exp_t;

    vec_t vecs[14];
    exp_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int gcnt = 0;
        bit done = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        sbaddress = v.addr; sbdata = v.wdat; acc = v.acc;
        roa = v.roa; rod = v.rod; ainc = v.ainc; rerr = v.rerr; roth = v.roth; rdata = v.rdat;
        aw = v.aw; dw = v.dw; dr = v.dr;
        sb_q.push_back('{v.xev_err, v.xerr, v.xev_dat, v.xdat});
        step();
        aw = 0; dw = 0; dr = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            gnt = 0; rvalid = 0;
            if (n_evalid || n_dvalid || !n_busy) begin
                done = 1;
            end else begin
                if (n_req) begin
                    if (gcnt == 0) begin
                        chk({tag, " master_add"}, n_add, v.madd);
                        chk({tag, " master_be"}, n_be, v.be);
                        chk({tag, " master_we"}, n_we, v.dw);
                        chk({tag, " master_wdata"}, n_wdata, v.wd);
                    end
                    if (gcnt == v.gdly) gnt = 1;
                    gcnt++;
                end else begin
                    rvalid = 1;
                end
                step();
            end
        end
        if (!done) chk({tag, " completion within budget"}, 0, 1);
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard underflow"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " sberror_valid"}, n_evalid, e.ev_err);
            if (e.ev_err) chk({tag, " sberror"}, n_err, e.err);
            chk({tag, " sbdata_valid"}, n_dvalid, e.ev_dat);
            if (e.ev_dat) chk({tag, " sbdata"}, n_sbdata, e.dat);
        end
        chk({tag, " req cycles"}, gcnt, v.req_cyc);
        chk({tag, " sbaddress"}, n_sbaddress, v.xaddr);
        chk({tag, " idle busy/req"}, {n_busy, n_req}, 0);
        step();
        chk({tag, " pulses one cycle"}, {n_evalid, n_dvalid}, 0);
        ainc = 0; rerr = 0; roth = 0;
    endtask

    initial begin
        //            aw dw dr roa rod ainc acc addr          wdat   gdly rdat          rerr roth req madd          be     wd         ee err ed dat           xaddr
        vecs[0]  = '{1, 0, 0, 1, 0, 0, 2, 32'h1000,     0,     2,  32'hDEADBEEF, 0, 0, 3, 32'h1000,     4'hF, 0,         0, 0, 1, 32'hDEADBEEF, 32'h1000};
        vecs[1]  = '{1, 0, 0, 1, 0, 0, 2, 32'h1002,     0,     0,  0,            0, 0, 0, 0,            4'h0, 0,         1, 3, 0, 0,            32'h1002};
        vecs[2]  = '{0, 0, 1, 0, 1, 0, 3, 0,            0,     0,  0,            0, 0, 0, 0,            4'h0, 0,         1, 4, 0, 0,            32'h1002};
        vecs[3]  = '{1, 0, 0, 1, 0, 1, 1, 32'h1002,     0,     0,  32'hCAFE1234, 0, 0, 1, 32'h1002,     4'hC, 0,         0, 0, 1, 32'h0000CAFE, 32'h1004};
        vecs[4]  = '{0, 1, 0, 0, 0, 1, 0, 0,            32'h5A, 1, 0,            0, 0, 2, 32'h1004,     4'h1, 32'h5A,    0, 0, 0, 0,            32'h1005};
        vecs[5]  = '{0, 1, 0, 0, 0, 1, 0, 0,            32'hA5, 0, 0,            1, 0, 1, 32'h1005,     4'h2, 32'hA500,  1, 2, 0, 0,            32'h1005};
        vecs[6]  = '{0, 0, 1, 0, 1, 1, 0, 0,            0,     0,  32'h12345678, 1, 1, 1, 32'h1005,     4'h2, 0,         1, 7, 0, 0,            32'h1005};
        vecs[7]  = '{1, 0, 0, 1, 0, 0, 2, 32'h2000,     0,     99, 0,            0, 0, 8, 32'h2000,     4'hF, 0,         1, 1, 0, 0,            32'h2000};
        vecs[8]  = '{1, 0, 0, 1, 0, 1, 2, 32'hFFFFFFFC, 0,     0,  32'h11223344, 0, 0, 1, 32'hFFFFFFFC, 4'hF, 0,         0, 0, 1, 32'h11223344, 32'h0};
        vecs[9]  = '{0, 0, 1, 0, 0, 0, 2, 0,            0,     0,  0,            0, 0, 0, 0,            4'h0, 0,         0, 0, 0, 0,            32'h0};
        vecs[10] = '{1, 0, 0, 0, 0, 0, 2, 32'h3001,     0,     0,  0,            0, 0, 0, 0,            4'h0, 0,         0, 0, 0, 0,            32'h3001};
        vecs[11] = '{0, 0, 1, 0, 1, 0, 1, 0,            0,     0,  0,            0, 0, 0, 0,            4'h0, 0,         1, 3, 0, 0,            32'h3001};
        vecs[12] = '{1, 0, 0, 1, 0, 0, 3, 32'h3003,     0,     0,  0,            0, 0, 0, 0,            4'h0, 0,         1, 4, 0, 0,            32'h3003};
        vecs[13] = '{1, 1, 0, 0, 0, 0, 2, 32'h4000,     32'h77, 0, 0,            0, 0, 0, 0,            4'h0, 0,         0, 0, 0, 0,            32'h4000};

        {aw, roa, ainc, dr, rod, dw, gnt, rvalid, rerr, roth} = '0;
        sbaddress = 0; sbdata = 0; rdata = 0; acc = 0;
        {w_aw, w_roa, w_ainc, w_dr, w_rod, w_dw, w_gnt, w_rvalid, w_rerr, w_roth} = '0;
        w_sbaddress = 0; w_sbdata = 0; w_rdata = 0; w_acc = 0;

        rst = 1;
        step(); step();
        rst = 0;
        chk("reset 32 outputs", {n_req, n_busy, n_evalid, n_dvalid, n_err, n_be, n_we}, 0);
        chk("reset 32 regs", {n_sbaddress, n_sbdata}, 0);
        chk("reset 64 outputs", {w_req, w_busy, w_evalid, w_dvalid, w_err, w_be}, 0);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // 64-bit byte write at an odd address with autoincrement, then a word read.
        w_sbaddress = 64'h2003; w_aw = 1;
        step();
        w_aw = 0; w_acc = 0; w_sbdata = 64'hA5; w_ainc = 1; w_dw = 1;
        step();
        w_dw = 0;
        chk("w64 req", w_req, 1);
        chk("w64 be", w_be, 8'h08);
        chk("w64 wdata[31:24]", w_wdata[31:24], 8'hA5);
        chk("w64 wdata", w_wdata, 64'hA500_0000);
        chk("w64 add", w_add, 64'h2003);
        w_gnt = 1;
        step();
        w_gnt = 0;
        chk("w64 wait req/busy", {w_req, w_busy}, 2'b01);
        w_rvalid = 1;
        step();
        w_rvalid = 0;
        chk("w64 done busy/err", {w_busy, w_evalid, w_dvalid}, 0);
        chk("w64 sbaddress", w_o_sbaddress, 64'h2004);
        w_acc = 2; w_rod = 1; w_dr = 1;
        step();
        w_dr = 0;
        chk("r64 be", w_be, 8'hF0);
        w_gnt = 1;
        step();
        w_gnt = 0; w_rvalid = 1; w_rdata = 64'h1122334455667788;
        step();
        w_rvalid = 0;
        chk("r64 sbdata_valid", w_dvalid, 1);
        chk("r64 sbdata", w_o_sbdata, 64'h11223344);
        chk("r64 sbaddress", w_o_sbaddress, 64'h2008);

        // Reset while waiting for a response; the late response must be dropped.
        sbaddress = 32'h1000; acc = 2; roa = 1; aw = 1;
        step();
        aw = 0; roa = 0;
        chk("rst seq req", n_req, 1);
        gnt = 1;
        step();
        gnt = 0;
        chk("rst seq in wait", {n_busy, n_req}, 2'b10);
        rst = 1;
        step();
        rst = 0;
        chk("rst seq outputs", {n_req, n_busy, n_evalid, n_dvalid, n_err, n_be}, 0);
        chk("rst seq regs", {n_sbaddress, n_sbdata}, 0);
        rvalid = 1; rdata = 32'hDEADBEEF;
        step();
        rvalid = 0;
        chk("rst seq late resp", {n_dvalid, n_evalid, n_busy, n_req}, 0);
        chk("rst seq sbdata", n_sbdata, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
